// File: rtl/mc_control.sv
// mc_control -- multicycle RISC-V subset control unit (lw, sw, add/sub/and/or, beq).
//
// Moore FSM that sequences a shared-ALU multicycle datapath. It also keeps a
// sticky flag for unsupported instructions and a wrapping count of retired
// instructions.
//
// Ports:
//   clk        in   1  sole clock, rising edge
//   rst_n      in   1  synchronous active-low reset
//   Opcode     in   7  instr[6:0], held stable outside FETCH
//   Funct3     in   3  instr[14:12]
//   Funct7b5   in   1  instr[30]
//   ZERO       in   1  ALU zero flag
//   ALUCtrl    out  4  0000 AND, 0001 OR, 0010 ADD, 0110 SUB
//   ALUSrcA    out  2  00 PC, 01 OldPC, 10 rs1
//   ALUSrcB    out  2  00 rs2, 01 imm, 10 constant 4
//   ResultSrc  out  2  00 ALUOut, 01 mem data, 10 ALU Y
//   AdrSrc     out  1  0 PC, 1 Result
//   IRWrite, MemWrite, RegWrite, PCWrite  out 1  write enables
//   Illegal    out  1  sticky unsupported-instruction flag
//   InstrCnt   out 16  retired-instruction count
//   State      out  4  current FSM state (debug)
module mc_control (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  Opcode,
    input  logic [2:0]  Funct3,
    input  logic        Funct7b5,
    input  logic        ZERO,
    output logic [3:0]  ALUCtrl,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ResultSrc,
    output logic        AdrSrc,
    output logic        IRWrite,
    output logic        MemWrite,
    output logic        RegWrite,
    output logic        PCWrite,
    output logic        Illegal,
    output logic [15:0] InstrCnt,
    output logic [3:0]  State
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        ALUWB    = 4'd7,
        BEQ      = 4'd8
    } state_t;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;

    state_t      r_state;
    state_t      w_next;
    logic        r_illegal;
    logic [15:0] r_instr_cnt;

    logic        w_is_lw;
    logic        w_is_sw;
    logic        w_is_rtype;
    logic        w_is_beq;
    logic        w_unsupported;
    logic        w_retire;
    logic [3:0]  w_rtype_alu;

    logic        w_irwrite;
    logic        w_memwrite;
    logic        w_regwrite;
    logic        w_pcwrite;

    // Instruction decode
    assign w_is_lw  = (Opcode == 7'b0000011) && (Funct3 == 3'b010);
    assign w_is_sw  = (Opcode == 7'b0100011) && (Funct3 == 3'b010);
    assign w_is_beq = (Opcode == 7'b1100011) && (Funct3 == 3'b000);

    // AND/OR require Funct7b5 = 0; ADD/SUB use it as the subtract select.
    always_comb begin
        w_is_rtype  = 1'b0;
        w_rtype_alu = ALU_ADD;
        if (Opcode == 7'b0110011) begin
            case (Funct3)
                3'b000: begin
                    w_is_rtype  = 1'b1;
                    w_rtype_alu = Funct7b5 ? ALU_SUB : ALU_ADD;
                end
                3'b111: begin
                    w_is_rtype  = !Funct7b5;
                    w_rtype_alu = ALU_AND;
                end
                3'b110: begin
                    w_is_rtype  = !Funct7b5;
                    w_rtype_alu = ALU_OR;
                end
                default: begin
                    w_is_rtype  = 1'b0;
                    w_rtype_alu = ALU_ADD;
                end
            endcase
        end
    end

    assign w_unsupported = !(w_is_lw || w_is_sw || w_is_rtype || w_is_beq);

    // An instruction retires on the edge that leaves its final state.
    assign w_retire = (r_state == MEMWB) || (r_state == MEMWRITE) ||
                      (r_state == ALUWB) || (r_state == BEQ);

    // Next-state logic
    always_comb begin
        w_next = FETCH;
        case (r_state)
            FETCH:   w_next = DECODE;
            DECODE: begin
                if (w_is_lw || w_is_sw) w_next = MEMADR;
                else if (w_is_rtype)    w_next = EXECR;
                else if (w_is_beq)      w_next = BEQ;
                else                    w_next = FETCH;
            end
            MEMADR:  w_next = w_is_lw ? MEMREAD : MEMWRITE;
            MEMREAD: w_next = MEMWB;
            EXECR:   w_next = ALUWB;
            default: w_next = FETCH;
        endcase
    end

    // State register, sticky illegal flag and retirement counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= FETCH;
            r_illegal   <= 1'b0;
            r_instr_cnt <= '0;
        end else begin
            r_state <= w_next;
            if ((r_state == DECODE) && w_unsupported)
                r_illegal <= 1'b1;
            if (w_retire)
                r_instr_cnt <= r_instr_cnt + 16'd1;
        end
    end

    // Moore outputs. BEQ PCWrite and EXECR ALUCtrl are the only paths that
    // depend combinationally on inputs.
    always_comb begin
        ALUCtrl    = ALU_ADD;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ResultSrc  = 2'b00;
        AdrSrc     = 1'b0;
        w_irwrite  = 1'b0;
        w_memwrite = 1'b0;
        w_regwrite = 1'b0;
        w_pcwrite  = 1'b0;
        case (r_state)
            FETCH: begin
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                w_irwrite = 1'b1;
                w_pcwrite = 1'b1;
            end
            DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
            end
            MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            MEMREAD: begin
                AdrSrc = 1'b1;
            end
            MEMWB: begin
                ResultSrc  = 2'b01;
                w_regwrite = 1'b1;
            end
            MEMWRITE: begin
                AdrSrc     = 1'b1;
                w_memwrite = 1'b1;
            end
            EXECR: begin
                ALUSrcA = 2'b10;
                ALUCtrl = w_rtype_alu;
            end
            ALUWB: begin
                w_regwrite = 1'b1;
            end
            BEQ: begin
                ALUSrcA   = 2'b10;
                ALUCtrl   = ALU_SUB;
                w_pcwrite = ZERO;
            end
            default: begin
                ALUCtrl = ALU_ADD;
            end
        endcase
    end

    // Write enables are suppressed while reset is held, independent of state.
    assign IRWrite  = w_irwrite  && rst_n;
    assign MemWrite = w_memwrite && rst_n;
    assign RegWrite = w_regwrite && rst_n;
    assign PCWrite  = w_pcwrite  && rst_n;

    assign Illegal  = r_illegal;
    assign InstrCnt = r_instr_cnt;
    assign State    = r_state;

endmodule

// File: tb/tb_mc_control.sv
// tb_mc_control -- self-checking bench for mc_control.
// The reference model tracks each instruction as a position in a fixed
// per-class state sequence (lw 5, sw 4, R 4, beq 3, illegal 2) and derives
// the outputs from a per-state table.
module tb_mc_control;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  Opcode;
    logic [2:0]  Funct3;
    logic        Funct7b5;
    logic        ZERO;
    logic [3:0]  ALUCtrl;
    logic [1:0]  ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic [1:0]  ResultSrc;
    logic        AdrSrc;
    logic        IRWrite;
    logic        MemWrite;
    logic        RegWrite;
    logic        PCWrite;
    logic        Illegal;
    logic [15:0] InstrCnt;
    logic [3:0]  State;

    mc_control dut (
        .clk(clk), .rst_n(rst_n), .Opcode(Opcode), .Funct3(Funct3),
        .Funct7b5(Funct7b5), .ZERO(ZERO), .ALUCtrl(ALUCtrl),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
        .AdrSrc(AdrSrc), .IRWrite(IRWrite), .MemWrite(MemWrite),
        .RegWrite(RegWrite), .PCWrite(PCWrite), .Illegal(Illegal),
        .InstrCnt(InstrCnt), .State(State)
    );

    always #5 clk = ~clk;

    localparam int unsigned C_LW = 0, C_SW = 1, C_R = 2, C_BEQ = 3, C_ILL = 4;

    int unsigned n_checks = 0;
    int unsigned n_err    = 0;

    int unsigned seq_tbl [5][5];
    int unsigned seq_len [5];
    int unsigned m_idx;
    logic        m_ill;
    logic [15:0] m_cnt;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", nm, $time, act, exp);
        end
    endtask

    function automatic int unsigned classify(input logic [6:0] op, input logic [2:0] f3, input logic f7);
        if (op == 7'b0000011 && f3 == 3'b010) return C_LW;
        if (op == 7'b0100011 && f3 == 3'b010) return C_SW;
        if (op == 7'b0110011 && (f3 == 3'b000 || (f3 == 3'b111 && !f7) || (f3 == 3'b110 && !f7)))
            return C_R;
        if (op == 7'b1100011 && f3 == 3'b000) return C_BEQ;
        return C_ILL;
    endfunction

    // Expected {ALUCtrl, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc, IRWrite, MemWrite, RegWrite, PCWrite}
    function automatic logic [14:0] exp_outs(input int unsigned st);
        logic [3:0] alu;
        logic [1:0] sa, sb, rs;
        logic       adr, irw, mw, rw, pcw;
        alu = 4'b0010; sa = 2'b00; sb = 2'b00; rs = 2'b00;
        adr = 0; irw = 0; mw = 0; rw = 0; pcw = 0;
        case (st)
            0: begin sb = 2'b10; rs = 2'b10; irw = 1; pcw = 1; end
            1: begin sa = 2'b01; sb = 2'b01; end
            2: begin sa = 2'b10; sb = 2'b01; end
            3: adr = 1;
            4: begin rs = 2'b01; rw = 1; end
            5: begin adr = 1; mw = 1; end
            6: begin
                sa = 2'b10;
                if (Funct3 == 3'b111)      alu = 4'b0000;
                else if (Funct3 == 3'b110) alu = 4'b0001;
                else                       alu = Funct7b5 ? 4'b0110 : 4'b0010;
            end
            7: rw = 1;
            8: begin sa = 2'b10; alu = 4'b0110; pcw = ZERO; end
            default: ;
        endcase
        if (!rst_n) begin irw = 0; mw = 0; rw = 0; pcw = 0; end
        return {alu, sa, sb, rs, adr, irw, mw, rw, pcw};
    endfunction

    // Compare every output against the model, 1 time unit after the falling edge.
    task automatic sample();
        int unsigned cls, st;
        #1;
        cls = classify(Opcode, Funct3, Funct7b5);
        st  = seq_tbl[cls][m_idx];
        chk("state", {28'd0, State}, st);
        chk("outputs", {17'd0, ALUCtrl, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc,
                        IRWrite, MemWrite, RegWrite, PCWrite}, {17'd0, exp_outs(st)});
        chk("illegal", {31'd0, Illegal}, {31'd0, m_ill});
        chk("instrcnt", {16'd0, InstrCnt}, {16'd0, m_cnt});
    endtask

    // Advance the model across one rising edge, then wait for the falling edge.
    task automatic advance();
        int unsigned cls;
        @(posedge clk);
        if (!rst_n) begin
            m_idx = 0; m_ill = 1'b0; m_cnt = '0;
        end else begin
            cls = classify(Opcode, Funct3, Funct7b5);
            if (m_idx + 1 >= seq_len[cls]) begin
                m_idx = 0;
                if (cls == C_ILL) m_ill = 1'b1;
                else              m_cnt = m_cnt + 16'd1;
            end else begin
                m_idx++;
            end
        end
        @(negedge clk);
    endtask

    task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7, input logic z);
        Opcode = op; Funct3 = f3; Funct7b5 = f7; ZERO = z;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        seq_tbl = '{'{0, 1, 2, 3, 4}, '{0, 1, 2, 5, 0}, '{0, 1, 6, 7, 0},
                    '{0, 1, 8, 0, 0}, '{0, 1, 0, 0, 0}};
        seq_len = '{5, 4, 4, 3, 2};
        m_idx = 0; m_ill = 1'b0; m_cnt = '0;

        rst_n = 1'b0;
        set_instr(7'b0000011, 3'b010, 1'b0, 1'b0);
        @(negedge clk);
        advance();
        sample();
        advance();
        rst_n = 1'b1;

        // lw
        for (int k = 0; k < 5; k++) begin
            sample();
            if (k == 0) begin
                chk("rst_fetch_irwrite", {31'd0, IRWrite}, 32'd1);
                chk("rst_fetch_pcwrite", {31'd0, PCWrite}, 32'd1);
                chk("rst_fetch_srcb", {30'd0, ALUSrcB}, 32'd2);
                chk("rst_cnt", {16'd0, InstrCnt}, 32'd0);
                chk("rst_illegal", {31'd0, Illegal}, 32'd0);
            end
            chk("lw_state", {28'd0, State}, k);
            chk("lw_regwrite", {31'd0, RegWrite}, (k == 4) ? 32'd1 : 32'd0);
            if (k == 4) chk("lw_ressrc", {30'd0, ResultSrc}, 32'd1);
            advance();
        end

        // sub
        set_instr(7'b0110011, 3'b000, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            sample();
            if (k == 0) chk("lw_cnt", {16'd0, InstrCnt}, 32'd1);
            chk("sub_state", {28'd0, State}, (k < 2) ? k : k + 4);
            if (k == 2) begin
                chk("sub_aluctrl", {28'd0, ALUCtrl}, 32'd6);
                chk("sub_srcb", {30'd0, ALUSrcB}, 32'd0);
            end
            if (k == 3) chk("sub_regwrite", {31'd0, RegWrite}, 32'd1);
            advance();
        end

        // beq taken, then not taken
        for (int b = 0; b < 2; b++) begin
            set_instr(7'b1100011, 3'b000, 1'b0, (b == 0));
            for (int k = 0; k < 3; k++) begin
                sample();
                if (k == 0) chk("beq_cnt", {16'd0, InstrCnt}, 2 + b);
                chk("beq_state", {28'd0, State}, (k < 2) ? k : 8);
                if (k == 2) chk("beq_pcwrite", {31'd0, PCWrite}, (b == 0) ? 32'd1 : 32'd0);
                advance();
            end
        end

        // unsupported opcode
        set_instr(7'b0010011, 3'b000, 1'b0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            sample();
            if (k == 0) chk("ill_cnt_before", {16'd0, InstrCnt}, 32'd4);
            chk("ill_illegal_before", {31'd0, Illegal}, 32'd0);
            chk("ill_memwrite", {31'd0, MemWrite}, 32'd0);
            chk("ill_regwrite", {31'd0, RegWrite}, 32'd0);
            advance();
        end
        sample();
        chk("ill_state", {28'd0, State}, 32'd0);
        chk("ill_illegal", {31'd0, Illegal}, 32'd1);
        chk("ill_cnt", {16'd0, InstrCnt}, 32'd4);

        // sw interrupted by reset in MEMADR
        set_instr(7'b0100011, 3'b010, 1'b0, 1'b0);
        advance();
        sample();
        advance();
        rst_n = 1'b0;
        sample();
        chk("swrst_state", {28'd0, State}, 32'd2);
        chk("swrst_memwrite", {31'd0, MemWrite}, 32'd0);
        advance();
        rst_n = 1'b1;
        sample();
        chk("swrst_state_after", {28'd0, State}, 32'd0);
        chk("swrst_memwrite_after", {31'd0, MemWrite}, 32'd0);
        chk("swrst_illegal", {31'd0, Illegal}, 32'd0);
        chk("swrst_cnt", {16'd0, InstrCnt}, 32'd0);
        advance();

        // randomized instruction stream with occasional resets
        for (int c = 0; c < 3000; c++) begin
            if (m_idx == 0) begin
                Funct7b5 = 1'($urandom);
                case ($urandom_range(0, 4))
                    0: begin
                        Opcode = 7'b0000011;
                        Funct3 = ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'b010;
                    end
                    1: begin
                        Opcode = 7'b0100011;
                        Funct3 = ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'b010;
                    end
                    2: begin
                        Opcode = 7'b0110011;
                        case ($urandom_range(0, 3))
                            0: Funct3 = 3'b000;
                            1: Funct3 = 3'b111;
                            2: Funct3 = 3'b110;
                            default: Funct3 = 3'($urandom);
                        endcase
                    end
                    3: begin
                        Opcode = 7'b1100011;
                        Funct3 = ($urandom_range(0, 5) == 0) ? 3'($urandom) : 3'b000;
                    end
                    default: begin
                        Opcode = 7'($urandom);
                        Funct3 = 3'($urandom);
                    end
                endcase
            end
            ZERO  = 1'($urandom);
            rst_n = ($urandom_range(0, 39) != 0);
            sample();
            advance();
        end

        // counter wrap: preload FFFF, then retire one beq
        rst_n = 1'b0;
        sample();
        advance();
        rst_n = 1'b1;
        force dut.r_instr_cnt = 16'hFFFF;
        #1;
        release dut.r_instr_cnt;
        m_cnt = 16'hFFFF;
        set_instr(7'b1100011, 3'b000, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            sample();
            if (k == 0) chk("wrap_preload", {16'd0, InstrCnt}, 32'h0000FFFF);
            advance();
        end
        sample();
        chk("wrap_cnt", {16'd0, InstrCnt}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
